// File: rtl/ddfs_freq_meter.sv
// Measures the frequency of a signed sine stream as a DDFS tuning word by counting Schmitt rising
// crossings over a crossing-aligned gate of 2^GATE_LOG2 valid samples; result 2 edges after index-N capture, no backpressure.
module ddfs_freq_meter #(
    parameter int ACC_W     = 23,
    parameter int DATA_W    = 8,
    parameter int GATE_LOG2 = 16,
    parameter int HYST      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [ACC_W-1:0]  fword,
    output logic              fword_valid,
    output logic              no_signal,
    output logic              busy
);

    localparam logic signed [DATA_W-1:0] THR_HI   = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] THR_LO   = DATA_W'(-HYST);
    localparam logic [GATE_LOG2-1:0]     IDX_LAST = '1;

    typedef enum logic [1:0] {IDLE, SYNC, GATE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [DATA_W-1:0]      din_r;
    logic                   din_r_vld;
    logic                   sch_hi;
    logic                   rise, fall, last;
    logic [GATE_LOG2-1:0]   idx;
    logic [GATE_LOG2-1:0]   cnt;
    logic                   timeout;
    logic [ACC_W-1:0]       cnt_word;

    assign rise     = din_r_vld && !sch_hi && ($signed(din_r) >= THR_HI);
    assign fall     = din_r_vld &&  sch_hi && ($signed(din_r) <= THR_LO);
    assign last     = (idx == IDX_LAST);
    assign cnt_word = ACC_W'(cnt) << (ACC_W - GATE_LOG2);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = SYNC;
            SYNC: begin
                if (!en)                   state_nxt = IDLE;
                else if (rise)             state_nxt = GATE;
                else if (din_r_vld && last) state_nxt = DONE;
            end
            GATE: begin
                if (!en)                   state_nxt = IDLE;
                else if (din_r_vld && last) state_nxt = DONE;
            end
            DONE:    state_nxt = en ? SYNC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx doubles as the sync timeout counter in SYNC and the sample index in GATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r       <= '0;
            din_r_vld   <= 1'b0;
            sch_hi      <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
            timeout     <= 1'b0;
            fword       <= '0;
            fword_valid <= 1'b0;
            no_signal   <= 1'b0;
        end else begin
            din_r       <= din;
            din_r_vld   <= din_valid;
            fword_valid <= 1'b0;
            if (rise) begin
                sch_hi <= 1'b1;
            end else if (fall) begin
                sch_hi <= 1'b0;
            end
            case (state)
                IDLE: begin
                    idx     <= '0;
                    cnt     <= '0;
                    timeout <= 1'b0;
                end
                SYNC: begin
                    timeout <= (state_nxt == DONE);
                    if (state_nxt == GATE) begin
                        idx <= '0;
                        cnt <= '0;
                    end else if (din_r_vld) begin
                        idx <= idx + 1'b1;
                    end
                end
                GATE: begin
                    timeout <= 1'b0;
                    if (din_r_vld) begin
                        idx <= idx + 1'b1;
                        if (rise) cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    fword_valid <= 1'b1;
                    no_signal   <= timeout;
                    fword       <= timeout ? '0 : cnt_word;
                    idx         <= '0;
                    cnt         <= '0;
                end
                default: begin
                    idx <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
